signed_seq_alu: RTL and testbench
=================================

Name: signed_seq_alu

Overview:
Parametrised, multi-cycle signed arithmetic unit: add, subtract, multiply, divide on WIDTH-bit two's-complement operands.
- Add/sub complete in one cycle.
- Multiply and divide run iteratively, one bit per cycle.
- Full double-width product and remainder are returned.
- Overflow and divide-by-zero are flagged.
- Sits in the ALU arithmetic path, driven by a start/busy/done handshake from the control unit.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
OpCode  input  2  00 add, 01 sub, 10 mul, 11 div
A  input  WIDTH  signed operand / dividend
B  input  WIDTH  signed operand / divisor
busy  output  1  operation in progress; start ignored
done  output  1  one-cycle pulse: results valid
Answer  output  WIDTH  sum / difference / product low half / quotient
AnswerHi  output  WIDTH  product high half (mul), remainder (div), 0 (add/sub)
Overflow  output  1  signed overflow (see rules)
DivByZero  output  1  div with B=0

Behaviour:
- Reset (reset=1 at an edge):
  - state IDLE; busy=0, done=0, Answer=0, AnswerHi=0, Overflow=0, DivByZero=0.
  - Any in-flight operation is abandoned; no done is issued for it.
  - reset has priority over start.
- States: IDLE, ITER, FIX. busy=1 in ITER and FIX, else 0.
- Accept: at an edge with state IDLE and start=1, latch A, B, OpCode. start while busy is ignored, with no effect.
- Add/sub:
  - Result is registered at the accepting edge; done=1 in the following cycle (latency 1).
  - State stays IDLE.
  - Overflow = operand signs equal (add) or differ (sub) and result sign differs from A. AnswerHi=0.
- Mul/div (B!=0):
  - IDLE->ITER at accept. Operands are converted to magnitudes; result sign is recorded; bit counter is loaded with WIDTH.
  - ITER performs one shift-add (mul) or restoring shift-subtract (div) step per edge, WIDTH edges, then ->FIX.
  - FIX applies sign correction, registers the outputs, sets done, ->IDLE.
  - Total latency accept-edge to done = WIDTH+1 cycles.
- Mul: {AnswerHi,Answer} = full 2*WIDTH signed product. Overflow=1 iff AnswerHi is not the sign-extension of Answer[WIDTH-1].
- Div:
  - Truncates toward zero; remainder takes the sign of the dividend; A = Q*B + R always holds.
  - A=MIN, B=-1: Answer=MIN, AnswerHi=0, Overflow=1, full latency.
- Div with B=0: short-circuit at the accept edge. done next cycle; Answer=all ones, AnswerHi=A, DivByZero=1, Overflow=0; state stays IDLE.
- Flags: Overflow and DivByZero are cleared on every done not setting them.
- Output hold: all result outputs hold until the next done or reset. done is high for exactly one cycle per accepted operation.
- Back-to-back: busy=0 during the done cycle, so a start in that cycle is accepted (zero bubble).
- Operand changes after acceptance have no effect.

Test Plan:
- Add, A=0x7FFFFFFF, B=1 -> done 1 cycle later; Answer=0x80000000, Overflow=1, AnswerHi=0.
- Mul, A=-3, B=7 -> done 33 cycles after accept; Answer=0xFFFFFFEB, AnswerHi=0xFFFFFFFF, Overflow=0. Then A=0x00010000, B=0x00010000 -> Answer=0, AnswerHi=1, Overflow=1.
- Div, A=-7, B=2 -> Answer=0xFFFFFFFD, AnswerHi=0xFFFFFFFF. Then A=7, B=-2 -> Answer=0xFFFFFFFD, AnswerHi=1; latency 33.
- Div, A=5, B=0 -> done 1 cycle later; Answer=0xFFFFFFFF, AnswerHi=5, DivByZero=1. Next op (sub 3-5) -> Answer=0xFFFFFFFE, DivByZero=0.
- Div, A=0x80000000, B=-1 -> Answer=0x80000000, AnswerHi=0, Overflow=1.
- Mul, start, then:
  - Hold start high and change A during busy -> exactly one done, result of original operands.
  - Assert reset at cycle 10 -> no done, all outputs 0, busy=0.
  - start the cycle after reset -> accepted.
- Repeat the key cases with WIDTH=8, e.g. mul -128*-128 -> {AnswerHi,Answer}=0x4000, Overflow=1, latency 9.

Source files
------------

// File: rtl/signed_seq_alu.sv
// Multi-cycle signed ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide. Results and flags are registered and held until the next done.
module signed_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       OpCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Answer,
    output logic [WIDTH-1:0] AnswerHi,
    output logic             Overflow,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             accept;
    logic             iterative_op;
    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic             add_ovf;
    logic             sub_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               mul_ovf;
    logic               div_ovf;

    // Operand preparation and the single-cycle add/sub path.
    always_comb begin
        accept       = (state == IDLE) && start;
        b_zero       = (B == '0);
        iterative_op = OpCode[1] && !((OpCode == OP_DIV) && b_zero);
        a_neg        = A[WIDTH-1];
        b_neg        = B[WIDTH-1];
        a_mag        = a_neg ? (-A) : A;
        b_mag        = b_neg ? (-B) : B;
        add_sum      = A + B;
        sub_diff     = A - B;
        add_ovf      = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
        sub_ovf      = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
    end

    // One iteration step. For div the partial remainder stays below the divisor,
    // so the W-bit difference is exact whenever the trial subtraction succeeds.
    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
        div_shift   = {work_hi, work_lo[WIDTH-1]};
        div_ok      = (div_shift >= {1'b0, mag_b});
        div_diff    = div_shift[WIDTH-1:0] - mag_b;
        div_hi_next = div_ok ? div_diff : div_shift[WIDTH-1:0];
        div_lo_next = {work_lo[WIDTH-2:0], div_ok};
    end

    // Sign correction; a non-negative quotient with its top bit set only arises from MIN / -1.
    always_comb begin
        prod_fix = neg_res ? (-{work_hi, work_lo}) : {work_hi, work_lo};
        quot_fix = neg_res ? (-work_lo) : work_lo;
        rem_fix  = neg_rem ? (-work_hi) : work_hi;
        mul_ovf  = (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
        div_ovf  = !neg_res && work_lo[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && iterative_op) next_state = ITER;
            ITER:    if (count == CW'(1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            Answer    <= '0;
            AnswerHi  <= '0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
            count     <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            mag_b     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (OpCode)
                            OP_ADD: begin
                                Answer    <= add_sum;
                                AnswerHi  <= '0;
                                Overflow  <= add_ovf;
                                DivByZero <= 1'b0;
                                done      <= 1'b1;
                            end
                            OP_SUB: begin
                                Answer    <= sub_diff;
                                AnswerHi  <= '0;
                                Overflow  <= sub_ovf;
                                DivByZero <= 1'b0;
                                done      <= 1'b1;
                            end
                            default: begin
                                if ((OpCode == OP_DIV) && b_zero) begin
                                    Answer    <= '1;
                                    AnswerHi  <= A;
                                    Overflow  <= 1'b0;
                                    DivByZero <= 1'b1;
                                    done      <= 1'b1;
                                end else begin
                                    is_div  <= (OpCode == OP_DIV);
                                    neg_res <= a_neg ^ b_neg;
                                    neg_rem <= a_neg;
                                    mag_b   <= b_mag;
                                    work_hi <= '0;
                                    work_lo <= a_mag;
                                    count   <= CW'(WIDTH);
                                end
                            end
                        endcase
                    end
                end
                ITER: begin
                    work_hi <= is_div ? div_hi_next : mul_hi_next;
                    work_lo <= is_div ? div_lo_next : mul_lo_next;
                    count   <= count - CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        Answer   <= quot_fix;
                        AnswerHi <= rem_fix;
                        Overflow <= div_ovf;
                    end else begin
                        Answer   <= prod_fix[WIDTH-1:0];
                        AnswerHi <= prod_fix[2*WIDTH-1:WIDTH];
                        Overflow <= mul_ovf;
                    end
                    DivByZero <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_alu.sv
// Randomized bench for signed_seq_alu at WIDTH=32 and WIDTH=8, checked against
// a plain-arithmetic reference model of the signed operations.
module tb_signed_seq_alu;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32, done32, ovf32, dbz32;
    logic [31:0] ans32, hi32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, ovf8, dbz8;
    logic [7:0]  ans8, hi8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    signed_seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .OpCode(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .Answer(ans32), .AnswerHi(hi32),
        .Overflow(ovf32), .DivByZero(dbz32)
    );

    signed_seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .OpCode(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Answer(ans8), .AnswerHi(hi8),
        .Overflow(ovf8), .DivByZero(dbz8)
    );

    // Reference: exact signed arithmetic in 64 bits, then truncated to w bits.
    function automatic void model(input int w, input logic [1:0] op, input longint a,
                                  input longint b, output longint ans, output longint hi,
                                  output bit ovf, output bit dbz);
        longint mask, maxv, minv, r, q;
        mask = (longint'(1) << w) - 1;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        ans = 0; hi = 0; ovf = 0; dbz = 0;
        case (op)
            2'b00: begin r = a + b; ans = r & mask; ovf = (r > maxv) || (r < minv); end
            2'b01: begin r = a - b; ans = r & mask; ovf = (r > maxv) || (r < minv); end
            2'b10: begin
                r = a * b; ans = r & mask; hi = (r >>> w) & mask;
                ovf = (r > maxv) || (r < minv);
            end
            default: begin
                if (b == 0) begin
                    ans = mask; hi = a & mask; dbz = 1;
                end else begin
                    q = a / b; r = a % b;
                    ans = q & mask; hi = r & mask; ovf = (q > maxv) || (q < minv);
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input int w, input logic [1:0] op, input longint b);
        return (op[1] && !(op == 2'b11 && b == 0)) ? w + 1 : 0;
    endfunction

    // lat = edges after the accept edge until done is seen (0 = done in the very next cycle).
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy32, done32, ans32, hi32, ovf32, dbz32} !== 68'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset32: got %h expected 0", {busy32, done32, ans32, hi32, ovf32, dbz32});
        end
        tests_run++;
        if ({busy8, done8, ans8, hi8, ovf8, dbz8} !== 20'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset8: got %h expected 0", {busy8, done8, ans8, hi8, ovf8, dbz8});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check32(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
        longint ea, eh; bit eo, ed;
        model(32, op, longint'($signed(a)), longint'($signed(b)), ea, eh, eo, ed);
        tests_run++;
        if (lat !== exp_lat(32, op, longint'(b))) begin
            tests_failed++;
            $display("[TB] FAIL %s latency op=%0d a=%h b=%h: got %0d expected %0d",
                     name, op, a, b, lat, exp_lat(32, op, longint'(b)));
        end
        tests_run++;
        if ({ans32, hi32, ovf32, dbz32} !== {ea[31:0], eh[31:0], eo, ed}) begin
            tests_failed++;
            $display("[TB] FAIL %s result op=%0d a=%h b=%h: got %h_%h ovf=%b dbz=%b expected %h_%h ovf=%b dbz=%b",
                     name, op, a, b, ans32, hi32, ovf32, dbz32, ea[31:0], eh[31:0], eo, ed);
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] a, b; logic [1:0] op; int lat;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: begin op = 2'b00; a = 32'h7FFF_FFFF; b = 32'd1; end
                1: begin op = 2'b01; a = 32'h8000_0000; b = 32'd1; end
                2: begin op = 2'b00; a = 32'h8000_0000; b = 32'h8000_0000; end
                3: begin op = 2'b01; a = 32'd3; b = 32'd5; end
                default: begin op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
            endcase
            run32(op, a, b, lat);
            check32("addsub", op, a, b, lat);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b; int lat;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin a = -32'sd3; b = 32'd7; end
                1: begin a = 32'h0001_0000; b = 32'h0001_0000; end
                2: begin a = 32'h8000_0000; b = 32'h8000_0000; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: begin a = $urandom >> $urandom_range(0, 31); b = $urandom; end
            endcase
            run32(2'b10, a, b, lat);
            check32("mul", 2'b10, a, b, lat);
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b; int lat;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin a = -32'sd7; b = 32'd2; end
                1: begin a = 32'd7; b = -32'sd2; end
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = 32'h8000_0000; b = 32'd1; end
                default: begin
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                    if (b == 0) b = 32'd3;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
            endcase
            run32(2'b11, a, b, lat);
            check32("div", 2'b11, a, b, lat);
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        run32(2'b11, 32'd5, 32'd0, lat);
        check32("divzero", 2'b11, 32'd5, 32'd0, lat);
        run32(2'b01, 32'd3, 32'd5, lat);
        check32("after_divzero", 2'b01, 32'd3, 32'd5, lat);
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a0, b0, got_ans, got_hi; logic got_ovf;
        longint ea, eh; bit eo, ed; int dones;
        a0 = $urandom; b0 = $urandom;
        @(negedge clk);
        op32 = 2'b10; a32 = a0; b32 = b0; start32 = 1'b1;
        @(posedge clk); #1;
        dones = 0; got_ans = '0; got_hi = '0; got_ovf = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1;
            if (done32) begin
                dones++;
                if (dones == 1) begin got_ans = ans32; got_hi = hi32; got_ovf = ovf32; end
                start32 = 1'b0;
            end
        end
        start32 = 1'b0;
        model(32, 2'b10, longint'($signed(a0)), longint'($signed(b0)), ea, eh, eo, ed);
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore done count: got %0d expected 1", dones);
        end
        tests_run++;
        if ({got_ans, got_hi, got_ovf} !== {ea[31:0], eh[31:0], eo}) begin
            tests_failed++;
            $display("[TB] FAIL busy_ignore result: got %h_%h ovf=%b expected %h_%h ovf=%b",
                     got_ans, got_hi, got_ovf, ea[31:0], eh[31:0], eo);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] a, b; int extra;
        longint ea, eh; bit eo, ed;
        @(negedge clk);
        op32 = 2'b10; a32 = $urandom; b32 = $urandom; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy32, done32, ans32, hi32, ovf32, dbz32} !== 68'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midop outputs: got %h expected 0",
                     {busy32, done32, ans32, hi32, ovf32, dbz32});
        end
        a = $urandom; b = $urandom;
        @(negedge clk);
        reset = 1'b0;
        op32 = 2'b00; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        model(32, 2'b00, longint'($signed(a)), longint'($signed(b)), ea, eh, eo, ed);
        tests_run++;
        if ({done32, ans32, hi32, ovf32} !== {1'b1, ea[31:0], eh[31:0], eo}) begin
            tests_failed++;
            $display("[TB] FAIL start_after_reset: got done=%b %h_%h ovf=%b expected done=1 %h_%h ovf=%b",
                     done32, ans32, hi32, ovf32, ea[31:0], eh[31:0], eo);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abandoned_op done count: got %0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; int lat;
        run32(2'b00, 32'd10, 32'd20, lat);
        check32("b2b_first", 2'b00, 32'd10, 32'd20, lat);
        a = $urandom; b = $urandom;
        op32 = 2'b10; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        tests_run++;
        if (busy32 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b accept busy: got %b expected 1", busy32);
        end
        lat = 0;
        while (!done32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check32("b2b_second", 2'b10, a, b, lat);
    endtask

    task automatic test_width8();
        logic [7:0] a, b; logic [1:0] op; int lat;
        longint ea, eh; bit eo, ed;
        for (int i = 0; i < 18; i++) begin
            case (i)
                0: begin op = 2'b10; a = 8'h80; b = 8'h80; end
                1: begin op = 2'b11; a = 8'h80; b = 8'hFF; end
                2: begin op = 2'b11; a = -8'sd7; b = 8'd2; end
                3: begin op = 2'b00; a = 8'h7F; b = 8'd1; end
                4: begin op = 2'b11; a = 8'd5; b = 8'd0; end
                5: begin op = 2'b10; a = -8'sd3; b = 8'd7; end
                default: begin
                    op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
                end
            endcase
            run8(op, a, b, lat);
            model(8, op, longint'($signed(a)), longint'($signed(b)), ea, eh, eo, ed);
            tests_run++;
            if (lat !== exp_lat(8, op, longint'(b))) begin
                tests_failed++;
                $display("[TB] FAIL w8 latency op=%0d a=%h b=%h: got %0d expected %0d",
                         op, a, b, lat, exp_lat(8, op, longint'(b)));
            end
            tests_run++;
            if ({ans8, hi8, ovf8, dbz8} !== {ea[7:0], eh[7:0], eo, ed}) begin
                tests_failed++;
                $display("[TB] FAIL w8 result op=%0d a=%h b=%h: got %h_%h ovf=%b dbz=%b expected %h_%h ovf=%b dbz=%b",
                         op, a, b, ans8, hi8, ovf8, dbz8, ea[7:0], eh[7:0], eo, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_div_by_zero();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
